instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Program-load block: accepts mnemonic-level instruction requests and encodes them into 32-bit instruction words, using the opcode/func map of the processor's control unit.
- Buffers the words in a FIFO and writes them sequentially into instruction memory through a ready-gated write port.
- Sits between the testbench/boot host and the IF-stage instruction memory. It is the encoding end of the instruction format the control unit decodes.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width.
- BASE_ADDR, 0, first write address; word-aligned, must be less than 2^ADDR_W.
- DEPTH, 4, FIFO depth in words; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse: flush FIFO, clear flags, set address to BASE_ADDR
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_mnem  in  5  mnemonic code (see Behaviour)
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields
- in_imm  in  32  immediate, or byte target for j/jal
- im_we  out  1  write request to instruction memory
- im_ready  in  1  memory accepts the write this cycle
- im_addr  out  ADDR_W  byte address of the current write
- im_wdata  out  32  encoded word
- word_count  out  ADDR_W-1  words written since the last start/reset
- mem_full  out  1  capacity reached; sticky
- err_illegal  out  1  an illegal mnemonic was seen; sticky
- busy  out  1  FIFO non-empty

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low. Reset values: all outputs 0 except im_addr = BASE_ADDR; FIFO empty; all internal counters reset.
- Word format: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] func. I-type carries imm[15:0]. J-type carries in_imm[27:2].
- R-type, opcode 0x03, func given in parentheses:
  - mnem 0..8: add(0x20), and(0x24), nor(0x27), or(0x25), slt(0x2A), sltu(0x2B), sll(0x00), srl(0x02), sub(0x22). All fields used.
  - mnem 9 jr(0x08): rs only; all other fields 0.
  - mnem 10 lwn(0x21): rs, rt, rd used; shamt 0.
  - mnem 11 swn(0x13): rs, rd used; rt and shamt 0.
- J-type: mnem 12 j (opcode 0x02), mnem 13 jal (opcode 0x07).
- I-type, rs/rt/imm: mnem 14 addi 0x09, 15 andi 0x0C, 16 beq 0x05, 17 bne 0x04, 18 lbu 0x22, 19 lui 0x0F (rs forced to 0), 20 lw 0x12, 21 ori 0x0E, 22 sb 0x28, 23 sw 0x2B.
- Illegal mnemonics: codes 24..31 set err_illegal. The request is consumed and no word is pushed.
- Accept rule: in_ready = !fifo_full && !mem_full && !start.
- Accept path: encoding is combinational. The word is pushed into the FIFO at the accepting edge.
- Capacity: CAP = (2^ADDR_W - BASE_ADDR)/4.
  - An accept counter counts pushed words.
  - mem_full asserts the cycle after the push that makes the count equal CAP.
  - Further requests are refused until start.
- Drain side: im_we = FIFO non-empty; im_wdata = FIFO head (registered, first-word-fall-through).
- Write completion: a write completes on im_we && im_ready. On completion: pop, im_addr += 4, word_count += 1.
- Hold rule: while im_ready is low, im_addr and im_wdata hold stable.
- Latency: a request accepted at edge N gives im_we high in cycle N+1, if the FIFO was empty.
- Push and pop in the same cycle: both occur and the count is unchanged. When the FIFO is full, in_ready is low even if a pop occurs that cycle.
- Address wrap: never occurs, because capacity gating stops accepts at CAP.
- start: takes precedence over in_valid and im_ready.
  - Empties the FIFO; pending words are discarded and never written.
  - im_addr = BASE_ADDR; word_count, the accept counter, mem_full and err_illegal cleared.
  - im_we is low in the next cycle.
- Reset mid-write: the write is abandoned and im_we drops on the reset edge.

Optional Feature:
- Macro: ENCODER_IMM_CHECK_EN.
- When defined, in_imm is range-checked:
  - Sign-extended types (addi, beq, bne, lbu, lw, sb, sw): in_imm[31:15] must be all 0 or all 1.
  - Zero-extended types (andi, ori, lui): in_imm[31:16] must be 0.
  - j/jal: in_imm[1:0] must be 0 and in_imm[31:28] must be 0.
  - Violation: the request is consumed, no word is pushed, and sticky output imm_err (1 bit, port present only under the macro) is set. imm_err is cleared by start/reset.
- When undefined: fields are silently truncated and there is no imm_err port.

Test Plan:
- R-type encoding: reset; send add rs=1, rt=2, rd=3 with im_ready=1 -> cycle after accept: im_we=1, im_addr=0x000, im_wdata=0x0C221820; word_count=1.
- I-type and J-type encoding: send lui rt=5 imm=0x1234, then jal imm=0x00000040 -> words 0x3C051234 at 0x000 and 0x1C000010 at 0x004.
- Backpressure: hold im_ready=0 and stream 5 legal requests -> 4 accepted, in_ready=0 on the 5th, im_addr/im_wdata stable; release im_ready -> 4 writes at 0x0, 0x4, 0x8, 0xC in consecutive cycles.
- Illegal mnemonic: send mnem=27 -> err_illegal=1, no write, im_addr unchanged; next legal request is written at the same address.
- Capacity: set BASE_ADDR=0x3F0 (CAP=4) and send 5 requests -> 4 writes ending at 0x3FC, mem_full=1, 5th refused; pulse start -> mem_full=0, im_addr=0x3F0.
- Flush during write: with 3 words queued and im_ready=0, pulse start together with in_valid -> FIFO empty, im_we=0 next cycle, request not accepted, word_count=0.
- Immediate check, with ENCODER_IMM_CHECK_EN defined: addi imm=0x00018000 -> imm_err=1, no write. Without the macro, the same request writes word 0x24008000 (rs=rt=0).

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write channels of the program loader.
// The loader itself connects through the slave modport; the boot host / bench through master.
interface instr_encoder_loader_if #(
   parameter int ADDR_W = 10
) ();
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        in_mnem;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [4:0]        in_shamt;
   logic [31:0]       in_imm;
   logic              im_we;
   logic              im_ready;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;

   modport master (
      output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, im_ready,
      input  in_ready, im_we, im_addr, im_wdata
   );

   modport slave (
      input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, im_ready,
      output in_ready, im_we, im_addr, im_wdata
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes mnemonic requests into 32-bit instruction words and streams them into instruction
// memory through a FIFO. Define ENCODER_IMM_CHECK_EN to range-check immediates (adds imm_err).
module instr_encoder_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   instr_encoder_loader_if.slave bus,
   output logic [ADDR_W-2:0]     word_count,
   output logic                  mem_full,
   output logic                  err_illegal,
`ifdef ENCODER_IMM_CHECK_EN
   output logic                  imm_err,
`endif
   output logic                  busy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CAP_I = ((1 << ADDR_W) - BASE_ADDR) / 4;
   localparam logic [ADDR_W-2:0] CAP = (ADDR_W-1)'(CAP_I);

   logic [31:0]       enc_word;
   logic              enc_legal;
   logic              imm_bad;
   logic              accept;
   logic              push;
   logic              pop;
   logic [31:0]       fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    fifo_cnt;
   logic              fifo_full;
   logic              fifo_empty;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-2:0] acc_cnt;
   logic [ADDR_W-2:0] acc_next;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] func);
      return {6'h03, rs, rt, rd, sh, func};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Mnemonic to instruction word, mirroring the control unit's opcode/func decode
   always_comb begin
      enc_word  = 32'h0;
      enc_legal = 1'b1;
      case (bus.in_mnem)
         5'd0:  enc_word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h20);
         5'd1:  enc_word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h24);
         5'd2:  enc_word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h27);
         5'd3:  enc_word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h25);
         5'd4:  enc_word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h2A);
         5'd5:  enc_word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h2B);
         5'd6:  enc_word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h00);
         5'd7:  enc_word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h02);
         5'd8:  enc_word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h22);
         5'd9:  enc_word = r_word(bus.in_rs, 5'd0, 5'd0, 5'd0, 6'h08);
         5'd10: enc_word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h21);
         5'd11: enc_word = r_word(bus.in_rs, 5'd0, bus.in_rd, 5'd0, 6'h13);
         5'd12: enc_word = {6'h02, bus.in_imm[27:2]};
         5'd13: enc_word = {6'h07, bus.in_imm[27:2]};
         5'd14: enc_word = i_word(6'h09, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
         5'd15: enc_word = i_word(6'h0C, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
         5'd16: enc_word = i_word(6'h05, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
         5'd17: enc_word = i_word(6'h04, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
         5'd18: enc_word = i_word(6'h22, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
         5'd19: enc_word = i_word(6'h0F, 5'd0, bus.in_rt, bus.in_imm[15:0]);
         5'd20: enc_word = i_word(6'h12, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
         5'd21: enc_word = i_word(6'h0E, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
         5'd22: enc_word = i_word(6'h28, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
         5'd23: enc_word = i_word(6'h2B, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
         default: enc_legal = 1'b0;
      endcase
   end

`ifdef ENCODER_IMM_CHECK_EN
   // Reject immediates that would not survive the truncation into the instruction field
   always_comb begin
      imm_bad = 1'b0;
      case (bus.in_mnem)
         5'd14, 5'd16, 5'd17, 5'd18, 5'd20, 5'd22, 5'd23:
            imm_bad = !((&bus.in_imm[31:15]) || !(|bus.in_imm[31:15]));
         5'd15, 5'd19, 5'd21:
            imm_bad = |bus.in_imm[31:16];
         5'd12, 5'd13:
            imm_bad = (|bus.in_imm[1:0]) || (|bus.in_imm[31:28]);
         default:
            imm_bad = 1'b0;
      endcase
   end
`else
   logic unused_imm_bits;
   assign imm_bad         = 1'b0;
   assign unused_imm_bits = ^bus.in_imm[31:28];
`endif

   assign fifo_full    = (fifo_cnt == (PTR_W+1)'(DEPTH));
   assign fifo_empty   = (fifo_cnt == '0);
   assign bus.in_ready = !fifo_full && !mem_full && !start;
   assign accept       = bus.in_valid && bus.in_ready;
   assign push         = accept && enc_legal && !imm_bad;
   assign pop          = bus.im_we && bus.im_ready;
   assign bus.im_we    = !fifo_empty;
   assign bus.im_wdata = fifo_mem[rd_ptr];
   assign bus.im_addr  = addr;
   assign busy         = !fifo_empty;
   assign acc_next     = acc_cnt + (ADDR_W-1)'(1);

   // FIFO storage; the head entry drives im_wdata directly (first-word-fall-through)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_mem[i] <= 32'h0;
         end
      end else if (push) begin
         fifo_mem[wr_ptr] <= enc_word;
      end
   end

   // FIFO pointers; start discards anything still queued
   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Write address, progress counters and sticky flags
   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         addr        <= ADDR_W'(BASE_ADDR);
         word_count  <= '0;
         acc_cnt     <= '0;
         mem_full    <= 1'b0;
         err_illegal <= 1'b0;
`ifdef ENCODER_IMM_CHECK_EN
         imm_err     <= 1'b0;
`endif
      end else begin
         if (pop) begin
            addr       <= addr + ADDR_W'(4);
            word_count <= word_count + (ADDR_W-1)'(1);
         end
         if (push) begin
            acc_cnt <= acc_next;
            if (acc_next == CAP) begin
               mem_full <= 1'b1;
            end
         end
         if (accept && !enc_legal) begin
            err_illegal <= 1'b1;
         end
`ifdef ENCODER_IMM_CHECK_EN
         if (accept && enc_legal && imm_bad) begin
            imm_err <= 1'b1;
         end
`endif
      end
   end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: scoreboarded write stream plus scenario tasks.
// Honours ENCODER_IMM_CHECK_EN the same way the design does.
module tb_instr_encoder_loader;
   localparam int ADDR_W = 10;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic start1;
   logic [ADDR_W-2:0] wc0, wc1;
   logic full0, full1, ill0, ill1, busy0, busy1;
`ifdef ENCODER_IMM_CHECK_EN
   logic ie0, ie1;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] sb[$];
   logic [ADDR_W-1:0] exp_addr;
   logic [31:0] mon_word;
   logic [31:0] mon_exp;
   logic        mon_ok;

   always #5 clk = ~clk;

   instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus0 ();
   instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus1 ();

   instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .DEPTH(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0),
      .word_count(wc0), .mem_full(full0), .err_illegal(ill0),
`ifdef ENCODER_IMM_CHECK_EN
      .imm_err(ie0),
`endif
      .busy(busy0)
   );

   instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h3F0), .DEPTH(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1),
      .word_count(wc1), .mem_full(full1), .err_illegal(ill1),
`ifdef ENCODER_IMM_CHECK_EN
      .imm_err(ie1),
`endif
      .busy(busy1)
   );

   // Reference encoding; returns 0 when the request must not produce a word
   function automatic logic model_encode(input logic [4:0] m, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [31:0] imm,
                                         output logic [31:0] w);
      logic [5:0] f;
      logic [5:0] op;
      logic ok;
      ok = 1'b1;
      w  = 32'h0;
      f  = 6'h0;
      op = 6'h0;
      if (m <= 5'd8) begin
         case (m)
            5'd0: f = 6'h20;  5'd1: f = 6'h24;  5'd2: f = 6'h27;
            5'd3: f = 6'h25;  5'd4: f = 6'h2A;  5'd5: f = 6'h2B;
            5'd6: f = 6'h00;  5'd7: f = 6'h02;  default: f = 6'h22;
         endcase
         w = {6'h03, rs, rt, rd, sh, f};
      end else if (m == 5'd9) begin
         w = {6'h03, rs, 15'd0, 6'h08};
      end else if (m == 5'd10) begin
         w = {6'h03, rs, rt, rd, 5'd0, 6'h21};
      end else if (m == 5'd11) begin
         w = {6'h03, rs, 5'd0, rd, 5'd0, 6'h13};
      end else if (m == 5'd12 || m == 5'd13) begin
         op = (m == 5'd12) ? 6'h02 : 6'h07;
         w  = {op, imm[27:2]};
`ifdef ENCODER_IMM_CHECK_EN
         ok = (imm[1:0] == 2'b00) && (imm[31:28] == 4'h0);
`endif
      end else if (m <= 5'd23) begin
         case (m)
            5'd14: op = 6'h09;  5'd15: op = 6'h0C;  5'd16: op = 6'h05;
            5'd17: op = 6'h04;  5'd18: op = 6'h22;  5'd19: op = 6'h0F;
            5'd20: op = 6'h12;  5'd21: op = 6'h0E;  5'd22: op = 6'h28;
            default: op = 6'h2B;
         endcase
         w = {op, (m == 5'd19) ? 5'd0 : rs, rt, imm[15:0]};
`ifdef ENCODER_IMM_CHECK_EN
         if (m == 5'd15 || m == 5'd19 || m == 5'd21)
            ok = (imm[31:16] == 16'h0);
         else
            ok = (imm[31:15] == 17'h0) || (imm[31:15] == 17'h1FFFF);
`endif
      end else begin
         ok = 1'b0;
      end
      if (!ok) w = 32'h0;
      return ok;
   endfunction

   // Scoreboard: push on accept, pop and compare on every completed write of dut0
   always @(negedge clk) begin
      if (!rst_n || start) begin
         sb.delete();
         exp_addr = '0;
      end else begin
         if (bus0.im_we && bus0.im_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL sb_unexpected_write: got addr %h data %h, required no write",
                        bus0.im_addr, bus0.im_wdata);
            end else begin
               mon_exp = sb.pop_front();
               if (bus0.im_wdata !== mon_exp || bus0.im_addr !== exp_addr) begin
                  n_fail++;
                  $display("[TB] FAIL sb_write: got %h@%h, required %h@%h",
                           bus0.im_wdata, bus0.im_addr, mon_exp, exp_addr);
               end
            end
            exp_addr = exp_addr + 10'd4;
         end
         if (bus0.in_valid && bus0.in_ready) begin
            mon_ok = model_encode(bus0.in_mnem, bus0.in_rs, bus0.in_rt, bus0.in_rd,
                                  bus0.in_shamt, bus0.in_imm, mon_word);
            if (mon_ok) sb.push_back(mon_word);
         end
      end
   end

   task automatic applyStimulus(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sh,
                                input logic [31:0] imm);
      int waits = 0;
      bus0.in_mnem = m;  bus0.in_rs = rs;  bus0.in_rt = rt;
      bus0.in_rd = rd;   bus0.in_shamt = sh; bus0.in_imm = imm;
      bus0.in_valid = 1'b1;
      @(negedge clk);
      while (!bus0.in_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (!bus0.in_ready) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL accept_timeout: got in_ready %b after %0d cycles, required 1",
                  bus0.in_ready, waits);
      end
      @(posedge clk);
      #1;
      bus0.in_valid = 1'b0;
   endtask

   task automatic pulse_start(input bit which);
      if (which) start1 = 1'b1; else start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      @(negedge clk);
      while ((busy0 || sb.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (busy0 || sb.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL drain_timeout: got busy %b queued %0d, required 0/0", busy0, sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
      bus0.in_valid = 1'b0; bus0.im_ready = 1'b0; bus0.in_mnem = '0; bus0.in_rs = '0;
      bus0.in_rt = '0; bus0.in_rd = '0; bus0.in_shamt = '0; bus0.in_imm = '0;
      bus1.in_valid = 1'b0; bus1.im_ready = 1'b0; bus1.in_mnem = '0; bus1.in_rs = '0;
      bus1.in_rt = '0; bus1.in_rd = '0; bus1.in_shamt = '0; bus1.in_imm = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus0.im_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %b required 0", bus0.im_we); end
      n_checks++; if (bus0.im_addr !== 10'h000) begin n_fail++; $display("[TB] FAIL reset_addr0: got %h required 000", bus0.im_addr); end
      n_checks++; if (bus1.im_addr !== 10'h3F0) begin n_fail++; $display("[TB] FAIL reset_addr1: got %h required 3f0", bus1.im_addr); end
      n_checks++; if (bus0.im_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_wdata: got %h required 0", bus0.im_wdata); end
      n_checks++; if (wc0 !== 9'd0) begin n_fail++; $display("[TB] FAIL reset_wc: got %0d required 0", wc0); end
      n_checks++; if ({full0, ill0, busy0} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b required 000", {full0, ill0, busy0}); end
`ifdef ENCODER_IMM_CHECK_EN
      n_checks++; if (ie0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_imm_err: got %b required 0", ie0); end
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_ready: got %b required 1", bus0.in_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_rtype();
      bus0.im_ready = 1'b1;
      applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
      @(negedge clk);
      n_checks++; if (bus0.im_we !== 1'b1) begin n_fail++; $display("[TB] FAIL rtype_we: got %b required 1", bus0.im_we); end
      n_checks++; if (bus0.im_addr !== 10'h000) begin n_fail++; $display("[TB] FAIL rtype_addr: got %h required 000", bus0.im_addr); end
      n_checks++; if (bus0.im_wdata !== 32'h0C221820) begin n_fail++; $display("[TB] FAIL rtype_word: got %h required 0c221820", bus0.im_wdata); end
      @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++; if (wc0 !== 9'd1) begin n_fail++; $display("[TB] FAIL rtype_wc: got %0d required 1", wc0); end
      @(posedge clk);
      #1;
      applyStimulus(5'd9,  5'd7,  5'd3,  5'd4,  5'd5,  32'h0);
      applyStimulus(5'd10, 5'd8,  5'd9,  5'd10, 5'd11, 32'h0);
      applyStimulus(5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 32'h0);
      applyStimulus(5'd6,  5'd0,  5'd17, 5'd18, 5'd31, 32'h0);
      wait_drain();
   endtask

   task automatic test_ij();
      pulse_start(1'b0);
      bus0.im_ready = 1'b1;
      applyStimulus(5'd19, 5'd9, 5'd5, 5'd0, 5'd0, 32'h00001234);
      @(negedge clk);
      n_checks++; if (bus0.im_wdata !== 32'h3C051234 || bus0.im_addr !== 10'h000) begin n_fail++; $display("[TB] FAIL lui_word: got %h@%h required 3c051234@000", bus0.im_wdata, bus0.im_addr); end
      @(posedge clk);
      #1;
      applyStimulus(5'd13, 5'd0, 5'd0, 5'd0, 5'd0, 32'h00000040);
      @(negedge clk);
      n_checks++; if (bus0.im_wdata !== 32'h1C000010 || bus0.im_addr !== 10'h004) begin n_fail++; $display("[TB] FAIL jal_word: got %h@%h required 1c000010@004", bus0.im_wdata, bus0.im_addr); end
      @(posedge clk);
      #1;
      wait_drain();
   endtask

   task automatic test_backpressure();
      logic [31:0] first_word;
      logic first_ok;
      pulse_start(1'b0);
      bus0.im_ready = 1'b0;
      first_ok = model_encode(5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 32'h0, first_word);
      applyStimulus(5'd3,  5'd4, 5'd5, 5'd6, 5'd7, 32'h0);
      applyStimulus(5'd14, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0000FFF0);
      applyStimulus(5'd12, 5'd0, 5'd0, 5'd0, 5'd0, 32'h00000100);
      applyStimulus(5'd23, 5'd29, 5'd30, 5'd0, 5'd0, 32'h00000008);
      bus0.in_mnem = 5'd1; bus0.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++; if (bus0.in_ready !== 1'b0 || busy0 !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_refuse: got ready %b busy %b required 0/1", bus0.in_ready, busy0); end
         n_checks++; if (!first_ok || bus0.im_addr !== 10'h000 || bus0.im_wdata !== first_word) begin n_fail++; $display("[TB] FAIL bp_hold: got %h@%h required %h@000", bus0.im_wdata, bus0.im_addr, first_word); end
      end
      @(posedge clk);
      #1;
      bus0.in_valid = 1'b0;
      bus0.im_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++; if (bus0.im_we !== 1'b1 || bus0.im_addr !== 10'(4 * k)) begin n_fail++; $display("[TB] FAIL bp_release: got we %b addr %h required 1/%h", bus0.im_we, bus0.im_addr, 10'(4 * k)); end
      end
      @(negedge clk);
      n_checks++; if (bus0.im_we !== 1'b0 || wc0 !== 9'd4) begin n_fail++; $display("[TB] FAIL bp_done: got we %b wc %0d required 0/4", bus0.im_we, wc0); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_illegal();
      pulse_start(1'b0);
      bus0.im_ready = 1'b1;
      applyStimulus(5'd27, 5'd1, 5'd1, 5'd1, 5'd1, 32'h0);
      @(negedge clk);
      n_checks++; if (ill0 !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal_flag: got %b required 1", ill0); end
      n_checks++; if (bus0.im_we !== 1'b0 || bus0.im_addr !== 10'h000) begin n_fail++; $display("[TB] FAIL illegal_nowrite: got we %b addr %h required 0/000", bus0.im_we, bus0.im_addr); end
      @(posedge clk);
      #1;
      applyStimulus(5'd21, 5'd3, 5'd4, 5'd0, 5'd0, 32'h0000BEEF);
      @(negedge clk);
      n_checks++; if (bus0.im_we !== 1'b1 || bus0.im_addr !== 10'h000 || bus0.im_wdata !== 32'h3864BEEF) begin n_fail++; $display("[TB] FAIL illegal_next: got %b %h@%h required 1 3864beef@000", bus0.im_we, bus0.im_wdata, bus0.im_addr); end
      n_checks++; if (ill0 !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal_sticky: got %b required 1", ill0); end
      @(posedge clk);
      #1;
      wait_drain();
   endtask

   task automatic test_flush();
      pulse_start(1'b0);
      bus0.im_ready = 1'b1;
      applyStimulus(5'd2, 5'd1, 5'd2, 5'd3, 5'd4, 32'h0);
      @(posedge clk);
      #1;
      bus0.im_ready = 1'b0;
      applyStimulus(5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 32'h0);
      applyStimulus(5'd5, 5'd9, 5'd10, 5'd11, 5'd12, 32'h0);
      applyStimulus(5'd7, 5'd13, 5'd14, 5'd15, 5'd16, 32'h0);
      bus0.in_mnem = 5'd0; bus0.in_valid = 1'b1; start = 1'b1;
      @(negedge clk);
      n_checks++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_ready: got %b required 0", bus0.in_ready); end
      n_checks++; if (wc0 !== 9'd1 || busy0 !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_pre: got wc %0d busy %b required 1/1", wc0, busy0); end
      @(posedge clk);
      #1;
      start = 1'b0; bus0.in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (bus0.im_we !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_empty: got we %b busy %b required 0/0", bus0.im_we, busy0); end
      n_checks++; if (wc0 !== 9'd0 || ill0 !== 1'b0 || bus0.im_addr !== 10'h000) begin n_fail++; $display("[TB] FAIL flush_clear: got wc %0d ill %b addr %h required 0/0/000", wc0, ill0, bus0.im_addr); end
      @(posedge clk);
      #1;
      bus0.im_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (bus0.im_we !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_discard: got we %b required 0", bus0.im_we); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_capacity();
      bus1.im_ready = 1'b1;
      bus1.in_mnem = 5'd0; bus1.in_rs = 5'd1; bus1.in_rt = 5'd2; bus1.in_rd = 5'd3;
      for (int k = 0; k < 4; k++) begin
         bus1.in_valid = 1'b1;
         @(negedge clk);
         n_checks++; if (bus1.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL cap_accept%0d: got %b required 1", k, bus1.in_ready); end
         if (k > 0) begin
            n_checks++; if (bus1.im_we !== 1'b1 || bus1.im_addr !== 10'(10'h3F0 + 4 * (k - 1))) begin n_fail++; $display("[TB] FAIL cap_write%0d: got we %b addr %h", k, bus1.im_we, bus1.im_addr); end
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      n_checks++; if (bus1.in_ready !== 1'b0 || full1 !== 1'b1) begin n_fail++; $display("[TB] FAIL cap_full: got ready %b full %b required 0/1", bus1.in_ready, full1); end
      n_checks++; if (bus1.im_we !== 1'b1 || bus1.im_addr !== 10'h3FC) begin n_fail++; $display("[TB] FAIL cap_last: got we %b addr %h required 1/3fc", bus1.im_we, bus1.im_addr); end
      repeat (4) @(negedge clk);
      n_checks++; if (wc1 !== 9'd4 || busy1 !== 1'b0 || full1 !== 1'b1) begin n_fail++; $display("[TB] FAIL cap_refused: got wc %0d busy %b full %b required 4/0/1", wc1, busy1, full1); end
      @(posedge clk);
      #1;
      bus1.in_valid = 1'b0;
      pulse_start(1'b1);
      @(negedge clk);
      n_checks++; if (full1 !== 1'b0 || bus1.im_addr !== 10'h3F0 || wc1 !== 9'd0) begin n_fail++; $display("[TB] FAIL cap_restart: got full %b addr %h wc %0d required 0/3f0/0", full1, bus1.im_addr, wc1); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_imm();
      pulse_start(1'b0);
      bus0.im_ready = 1'b1;
      applyStimulus(5'd14, 5'd0, 5'd0, 5'd0, 5'd0, 32'h00018000);
      @(negedge clk);
`ifdef ENCODER_IMM_CHECK_EN
      n_checks++; if (ie0 !== 1'b1 || bus0.im_we !== 1'b0) begin n_fail++; $display("[TB] FAIL imm_reject: got imm_err %b we %b required 1/0", ie0, bus0.im_we); end
      @(posedge clk);
      #1;
      pulse_start(1'b0);
      @(negedge clk);
      n_checks++; if (ie0 !== 1'b0) begin n_fail++; $display("[TB] FAIL imm_clear: got %b required 0", ie0); end
`else
      n_checks++; if (bus0.im_we !== 1'b1 || bus0.im_wdata !== 32'h24008000) begin n_fail++; $display("[TB] FAIL imm_truncate: got we %b word %h required 1/24008000", bus0.im_we, bus0.im_wdata); end
`endif
      @(posedge clk);
      #1;
      wait_drain();
   endtask

   task automatic test_back_to_back();
      bit done = 1'b0;
      pulse_start(1'b0);
      fork
         begin
            for (int k = 0; k < 12; k++) begin
               applyStimulus(5'($urandom_range(0, 23)), 5'($urandom), 5'($urandom),
                             5'($urandom), 5'($urandom), $urandom & 32'h00007FFC);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               bus0.im_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus0.im_ready = 1'b1;
      wait_drain();
      @(negedge clk);
      n_checks++; if (wc0 !== 9'd12) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d required 12", wc0); end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_ij();
      test_backpressure();
      test_illegal();
      test_flush();
      test_capacity();
      test_imm();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
